indirect_update_queue: RTL and testbench
========================================

INDIRECT_UPDATE_QUEUE -- requirements
Module: indirect_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of pending-update entries (power of two, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the mispredict statistics counter.
REQ-003 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port res_valid, input, 1 bit: a resolved indirect branch is presented.
REQ-006 Port res_ready, output, 1 bit: the queue can accept a resolved branch.
REQ-007 Ports res_pc, res_target and res_pred_target, input, 32 bits each: the branch PC, the actual target and the predicted target.
REQ-008 Port res_BHR, input, 10 bits: the history used at prediction time.
REQ-009 Port update_hold, input, 1 bit: when high, no write is issued this cycle.
REQ-010 Ports update_en (1 bit), update_pc (32 bits), update_target (32 bits) and update_BHR (10 bits), outputs: the write port toward the target cache.
REQ-011 Ports redirect_valid (1 bit) and redirect_pc (32 bits), outputs: the fetch redirect on a mispredict.
REQ-012 Port mispredict_cnt, output, CNT_W bits: the saturating mispredict count.

Function
REQ-013 A transfer SHALL occur when res_valid and res_ready are both high at a rising edge.
- res_ready = (count < DEPTH), or count == DEPTH with a pop occurring the same cycle.
REQ-014 A transfer with res_target != res_pred_target is a mispredict.
- It SHALL push {res_pc, res_target, res_BHR} into the FIFO.
- A transfer with matching targets SHALL be accepted and discarded, with no push.
REQ-015 On a mispredict transfer, the block SHALL drive redirect_valid = 1 and redirect_pc = res_target for exactly the following cycle (registered, 1-cycle latency).
- If there is no mispredict transfer, redirect_valid SHALL be 0.
REQ-016 Each mispredict transfer SHALL increment mispredict_cnt by 1, saturating at all-ones.
REQ-017 A pop SHALL occur when count > 0 and update_hold = 0.
- update_en SHALL be high in that cycle (combinational from the registered state).
- update_pc, update_target and update_BHR SHALL present the head entry.
- The head SHALL advance at the clock edge.
REQ-018 When update_en = 0, update_pc, update_target and update_BHR SHALL be 0.
REQ-019 Entries SHALL leave in strict FIFO order.
- Read and write pointers wrap modulo DEPTH.
- count is $clog2(DEPTH)+1 bits and never exceeds DEPTH.
REQ-020 A simultaneous push and pop SHALL leave count unchanged.
- This holds even when count == DEPTH (full plus pop accepts) and when count == 0.
- When count == 0, the FIFO is not bypassed: the new entry issues the next cycle at the earliest.
REQ-021 Minimum latency from a mispredict transfer to its update_en SHALL be 1 cycle.
REQ-022 A matching-target transfer while full SHALL still require res_ready (no special-case accept).

Reset
REQ-023 While reset is high at a clock edge, the following SHALL be cleared:
- count, the pointers and mispredict_cnt;
- redirect_valid = 0 and redirect_pc = 0.
REQ-024 During and after reset, update_en SHALL be 0 and res_ready SHALL be 1 (from the first cycle after reset).
REQ-025 Reset mid-operation SHALL discard all pending entries, with no write issued in the reset cycle.
- Entry storage contents need not be cleared.

Structure
REQ-026 A shared package SHALL hold:
- BHR_W = 10;
- the entry struct {pc[31:0], target[31:0], bhr[9:0]};
- the default DEPTH.
REQ-027 The storage and pointers SHALL be one sub-module, update_fifo (push, pop, full, empty, head), instantiated once.

Verification
REQ-028 After reset, present a single transfer pc=0x0000_1000, target=0x0000_2000, pred=0x0000_3000, BHR=0x155.
- The next cycle SHALL show redirect_valid=1 with redirect_pc=0x0000_2000.
- update_en=1 SHALL be driven with the same pc, target and BHR, and mispredict_cnt=1.
REQ-029 Present a transfer with target=pred=0x0000_4000.
- There SHALL be no update_en, no redirect, and mispredict_cnt unchanged.
REQ-030 With update_hold=1, present 5 mispredict transfers back-to-back.
- The first 4 SHALL be accepted; res_ready=0 on the 5th.
- After releasing the hold, 4 writes SHALL occur in order on consecutive cycles.
REQ-031 Hold the queue full, then drop update_hold while a 5th mispredict is presented.
- The 5th SHALL be accepted in the same cycle and count SHALL stay 4.
REQ-032 Assert reset with 3 entries pending.
- No update_en SHALL occur afterward, count=0, and mispredict_cnt=0.
REQ-033 Force mispredict_cnt to all-ones (via CNT_W=2 and 4 mispredicts).
- The counter SHALL stay at 3.

Source files
------------

// File: rtl/indirect_update_queue_pkg.sv
// rtl/indirect_update_queue_pkg.sv - shared types and constants for the indirect update queue
package indirect_update_queue_pkg;

    localparam int BHR_W         = 10;
    localparam int DEFAULT_DEPTH = 4;

    // One pending target-cache write: where the branch lives, where it
    // really went, and the history it was predicted with.
    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      target;
        logic [BHR_W-1:0] bhr;
    } iuq_entry_t;

endpackage

// File: rtl/indirect_update_queue_update_fifo.sv
// rtl/indirect_update_queue_update_fifo.sv - pending-update storage with wrapping pointers
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, push_data   enqueue one entry (taken when not full, or full with pop)
//   pop               dequeue the head entry (ignored when empty)
//   full, empty       occupancy flags
//   head              entry at the read pointer
module update_fifo
    import indirect_update_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  iuq_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output iuq_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    iuq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left uncleared by reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/indirect_update_queue.sv
// rtl/indirect_update_queue.sv - queues mispredicted indirect branches for target-cache update
//
// Ports:
//   clk, reset                       rising-edge clock, synchronous active-high reset
//   res_valid / res_ready            resolved-branch handshake
//   res_pc, res_target,
//   res_pred_target, res_BHR         resolved branch details
//   update_hold                      stall the target-cache write port
//   update_en, update_pc,
//   update_target, update_BHR        target-cache write port (zero when idle)
//   redirect_valid, redirect_pc      one-cycle fetch redirect after a mispredict
//   mispredict_cnt                   saturating mispredict count
module indirect_update_queue
    import indirect_update_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_target,
    input  logic [31:0]      res_pred_target,
    input  logic [BHR_W-1:0] res_BHR,
    input  logic             update_hold,
    output logic             update_en,
    output logic [31:0]      update_pc,
    output logic [31:0]      update_target,
    output logic [BHR_W-1:0] update_BHR,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic       fifo_full;
    logic       fifo_empty;
    iuq_entry_t fifo_head;
    iuq_entry_t push_entry;
    logic       pop;
    logic       xfer;
    logic       mispredict;

    // No write leaves during a reset cycle even if entries were pending.
    assign pop        = !reset && !fifo_empty && !update_hold;
    assign res_ready  = !fifo_full || pop;
    assign xfer       = res_valid && res_ready;
    // Correctly predicted branches are accepted and dropped.
    assign mispredict = xfer && (res_target != res_pred_target);

    assign push_entry = '{pc: res_pc, target: res_target, bhr: res_BHR};

    update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mispredict),
        .push_data (push_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign update_en     = pop;
    assign update_pc     = pop ? fifo_head.pc     : '0;
    assign update_target = pop ? fifo_head.target : '0;
    assign update_BHR    = pop ? fifo_head.bhr    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            redirect_valid <= mispredict;
            redirect_pc    <= mispredict ? res_target : '0;
            if (mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_indirect_update_queue.sv
// tb/tb_indirect_update_queue.sv - self-checking bench for indirect_update_queue
module tb_indirect_update_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic [31:0] res_pc, res_target, res_pred_target;
    logic [9:0]  res_BHR;
    logic        update_hold;

    logic        res_ready, update_en, redirect_valid;
    logic [31:0] update_pc, update_target, redirect_pc;
    logic [9:0]  update_BHR;
    logic [15:0] mispredict_cnt;

    logic        res_ready2, update_en2, redirect_valid2;
    logic [31:0] update_pc2, update_target2, redirect_pc2;
    logic [9:0]  update_BHR2;
    logic [1:0]  mispredict_cnt2;

    always #5 clk = ~clk;

    indirect_update_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target), .res_pred_target(res_pred_target),
        .res_BHR(res_BHR), .update_hold(update_hold), .update_en(update_en),
        .update_pc(update_pc), .update_target(update_target), .update_BHR(update_BHR),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mispredict_cnt(mispredict_cnt)
    );

    indirect_update_queue #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_ready(res_ready2),
        .res_pc(res_pc), .res_target(res_target), .res_pred_target(res_pred_target),
        .res_BHR(res_BHR), .update_hold(update_hold), .update_en(update_en2),
        .update_pc(update_pc2), .update_target(update_target2), .update_BHR(update_BHR2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .mispredict_cnt(mispredict_cnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of pending updates plus two counters.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [9:0]  bhr;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_cnt, m_cnt2;
    logic        m_rv;
    logic [31:0] m_rpc;

    task automatic model_reset();
        mq.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
        m_rv   = 1'b0;
        m_rpc  = 32'h0;
    endtask

    task automatic model_cycle(input string tag);
        bit          pop, rdy, mp;
        logic [31:0] epc, etgt;
        logic [9:0]  ebhr;
        ent_t        e;
        pop  = !reset && (mq.size() > 0) && !update_hold;
        rdy  = (mq.size() < 4) || pop;
        epc  = pop ? mq[0].pc : 32'h0;
        etgt = pop ? mq[0].target : 32'h0;
        ebhr = pop ? mq[0].bhr : 10'h0;
        chk({tag, "_ready"}, 32'(res_ready), 32'(rdy));
        chk({tag, "_en"}, 32'(update_en), 32'(pop));
        chk({tag, "_upc"}, update_pc, epc);
        chk({tag, "_utgt"}, update_target, etgt);
        chk({tag, "_ubhr"}, 32'(update_BHR), 32'(ebhr));
        chk({tag, "_rv"}, 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk({tag, "_rpc"}, redirect_pc, m_rpc);
        chk({tag, "_cnt"}, 32'(mispredict_cnt), m_cnt);
        chk({tag, "_count"}, 32'(dut.u_fifo.count), mq.size());
        chk({tag, "_ready2"}, 32'(res_ready2), 32'(rdy));
        chk({tag, "_en2"}, 32'(update_en2), 32'(pop));
        chk({tag, "_upc2"}, update_pc2, epc);
        chk({tag, "_utgt2"}, update_target2, etgt);
        chk({tag, "_ubhr2"}, 32'(update_BHR2), 32'(ebhr));
        chk({tag, "_rv2"}, 32'(redirect_valid2), 32'(m_rv));
        chk({tag, "_rpc2"}, redirect_pc2, redirect_pc2 === redirect_pc ? redirect_pc : m_rpc);
        chk({tag, "_cnt2"}, 32'(mispredict_cnt2), m_cnt2);
        if (reset) begin
            model_reset();
        end else begin
            mp = res_valid && rdy && (res_target != res_pred_target);
            if (pop) void'(mq.pop_front());
            if (mp) begin
                e.pc = res_pc; e.target = res_target; e.bhr = res_BHR;
                mq.push_back(e);
                if (m_cnt != 32'hFFFF) m_cnt++;
                if (m_cnt2 != 3) m_cnt2++;
            end
            m_rv  = mp;
            m_rpc = mp ? res_target : 32'h0;
        end
    endtask

    typedef struct {
        bit          rst, v, hold;
        logic [31:0] pc, tgt, pred;
        logic [9:0]  bhr;
        bit          e_ready, e_en;
        logic [31:0] e_upc, e_utgt;
        logic [9:0]  e_ubhr;
        bit          e_rv;
        logic [31:0] e_rpc;
        int          e_cnt, e_cnt2, e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, v, hold, input logic [31:0] pc, tgt, pred,
                       input logic [9:0] bhr, input bit e_ready, e_en,
                       input logic [31:0] e_upc, e_utgt, input logic [9:0] e_ubhr,
                       input bit e_rv, input logic [31:0] e_rpc,
                       input int e_cnt, e_cnt2, e_count);
        vec_t r;
        r.rst = rst; r.v = v; r.hold = hold; r.pc = pc; r.tgt = tgt; r.pred = pred;
        r.bhr = bhr; r.e_ready = e_ready; r.e_en = e_en; r.e_upc = e_upc;
        r.e_utgt = e_utgt; r.e_ubhr = e_ubhr; r.e_rv = e_rv; r.e_rpc = e_rpc;
        r.e_cnt = e_cnt; r.e_cnt2 = e_cnt2; r.e_count = e_count;
        vecs.push_back(r);
    endtask

    task automatic idle(input bit e_en, input logic [31:0] e_upc, e_utgt,
                        input logic [9:0] e_ubhr, input bit e_rv, input logic [31:0] e_rpc,
                        input int e_cnt, e_cnt2, e_count);
        add(0, 0, 0, 0, 0, 0, 0, 1, e_en, e_upc, e_utgt, e_ubhr, e_rv, e_rpc,
            e_cnt, e_cnt2, e_count);
    endtask

    initial begin
        string t;
        reset = 1'b1; res_valid = 1'b0; res_pc = '0; res_target = '0;
        res_pred_target = '0; res_BHR = '0; update_hold = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // single mispredict, then a correct prediction
        add(1, 0, 0, 0, 0, 0, 0,                            1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 32'h1000, 32'h2000, 32'h3000, 10'h155, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 32'h1000, 32'h2000, 10'h155, 1, 32'h2000, 1, 1, 1);
        add(0, 1, 0, 32'h1004, 32'h4000, 32'h4000, 0,       1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 1, 1, 0);
        // fill under hold, 5th refused
        add(0, 1, 1, 32'h100, 32'h200, 0, 0, 1, 0, 0, 0, 0, 0, 0,        1, 1, 0);
        add(0, 1, 1, 32'h104, 32'h201, 0, 1, 1, 0, 0, 0, 0, 1, 32'h200,  2, 2, 1);
        add(0, 1, 1, 32'h108, 32'h202, 0, 2, 1, 0, 0, 0, 0, 1, 32'h201,  3, 3, 2);
        add(0, 1, 1, 32'h10C, 32'h203, 0, 3, 1, 0, 0, 0, 0, 1, 32'h202,  4, 3, 3);
        add(0, 1, 1, 32'h110, 32'h204, 0, 4, 0, 0, 0, 0, 0, 1, 32'h203,  5, 3, 4);
        // release hold while the 5th is presented: full plus pop accepts
        add(0, 1, 0, 32'h110, 32'h204, 0, 4, 1, 1, 32'h100, 32'h200, 0, 0, 0, 5, 3, 4);
        idle(1, 32'h104, 32'h201, 1, 1, 32'h204, 6, 3, 4);
        idle(1, 32'h108, 32'h202, 2, 0, 0, 6, 3, 3);
        idle(1, 32'h10C, 32'h203, 3, 0, 0, 6, 3, 2);
        idle(1, 32'h110, 32'h204, 4, 0, 0, 6, 3, 1);
        idle(0, 0, 0, 0, 0, 0, 6, 3, 0);
        // three pending, then reset
        add(0, 1, 1, 32'h300, 32'h400, 0, 7, 1, 0, 0, 0, 0, 0, 0,        6, 3, 0);
        add(0, 1, 1, 32'h304, 32'h401, 0, 8, 1, 0, 0, 0, 0, 1, 32'h400,  7, 3, 1);
        add(0, 1, 1, 32'h308, 32'h402, 0, 9, 1, 0, 0, 0, 0, 1, 32'h401,  8, 3, 2);
        add(1, 0, 0, 0, 0, 0, 0,             1, 0, 0, 0, 0, 1, 32'h402,  9, 3, 3);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; res_valid = vecs[i].v; update_hold = vecs[i].hold;
            res_pc = vecs[i].pc; res_target = vecs[i].tgt;
            res_pred_target = vecs[i].pred; res_BHR = vecs[i].bhr;
            @(negedge clk);
            t = $sformatf("vec%0d", i);
            chk({t, "_ready"}, 32'(res_ready), 32'(vecs[i].e_ready));
            chk({t, "_en"}, 32'(update_en), 32'(vecs[i].e_en));
            chk({t, "_upc"}, update_pc, vecs[i].e_upc);
            chk({t, "_utgt"}, update_target, vecs[i].e_utgt);
            chk({t, "_ubhr"}, 32'(update_BHR), 32'(vecs[i].e_ubhr));
            chk({t, "_rv"}, 32'(redirect_valid), 32'(vecs[i].e_rv));
            if (vecs[i].e_rv) chk({t, "_rpc"}, redirect_pc, vecs[i].e_rpc);
            chk({t, "_cnt"}, 32'(mispredict_cnt), vecs[i].e_cnt);
            chk({t, "_cnt2"}, 32'(mispredict_cnt2), vecs[i].e_cnt2);
            chk({t, "_count"}, 32'(dut.u_fifo.count), vecs[i].e_count);
            model_cycle({t, "_m"});
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            res_valid   = ($urandom_range(0, 3) != 0);
            update_hold = ($urandom_range(0, 2) == 0);
            res_pc      = $urandom;
            res_target  = $urandom;
            res_pred_target = ($urandom_range(0, 3) == 0) ? res_target : $urandom;
            res_BHR     = 10'($urandom);
            @(negedge clk);
            model_cycle($sformatf("rnd%0d", i));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
